spi_reg_bridge: RTL and testbench
=================================

// Module: spi_reg_bridge
// PURPOSE
//  Byte-level command decoder downstream of the SPI slave: consumes received MOSI bytes and drives a
//  simple req/ack register bus. It returns read data to the slave's MISO loader, so an external
//  SPI master can read and write the SoC register space with address auto-increment.
// PARAMETERS
//  ADDR_W          7    register address width; the command byte carries ADDR_W<=7 bits.
//  TIMEOUT_CYCLES  64   bus ack timeout in i_clk cycles; used only with SPI_BRIDGE_TIMEOUT_EN.
// PORTS
//  i_clk        in   1       system clock.
//  i_rstn       in   1       synchronous, active-low reset.
//  i_spi_csn    in   1       chip select from the pad (already synchronous to i_clk); high = frame end.
//  i_rx_valid   in   1       1-cycle pulse: a byte has been received from MOSI.
//  i_rx_data    in   8       received byte; valid only with i_rx_valid.
//  o_tx_valid   out  1       1-cycle pulse: load o_tx_data into the MISO shifter.
//  o_tx_data    out  8       byte to transmit on MISO.
//  o_bus_req    out  1       bus request; held until ack.
//  o_bus_we     out  1       1 = write, 0 = read.
//  o_bus_addr   out  ADDR_W  bus address.
//  o_bus_wdata  out  8       write data.
//  i_bus_ack    in   1       bus completion, sampled while o_bus_req=1.
//  i_bus_rdata  in   8       read data, valid with i_bus_ack on reads.
//  o_err        out  1       sticky error flag; cleared on the csn falling edge (new frame).
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; internal address 0.
//  Frame format: byte0 = {rw, addr[6:0]} with rw=1 for write; following bytes are data.
//  Address: increments by 1 after each completed bus access and wraps modulo 2^ADDR_W.
//  Unused command address bits above ADDR_W are ignored.
//  States:
//   IDLE:    csn falling edge -> CMD; clear o_err.
//   CMD:     rx byte -> latch rw and addr.
//            rw=1 -> WR_WAIT.
//            rw=0 -> RD_BUS (prefetch the first read byte).
//   WR_WAIT: rx byte -> latch it into o_bus_wdata; raise req with we=1 -> WR_BUS.
//   WR_BUS:  ack -> addr+1, go to WR_WAIT.
//   RD_BUS:  req with we=0; on ack, capture rdata -> RD_LOAD.
//   RD_LOAD: one-cycle o_tx_valid pulse, o_tx_data = captured rdata; addr+1 -> RD_WAIT.
//   RD_WAIT: rx byte (exchange done; MOSI content ignored) -> RD_BUS (prefetch next byte).
//  Bus handshake:
//   - o_bus_req rises the cycle after the triggering event.
//   - addr, we and wdata are stable while req=1.
//   - req falls the cycle after i_bus_ack=1 is sampled.
//   - An ack arriving while req=0 is ignored.
//  Read latency:
//   - A read byte leaves the bridge on o_tx_valid 2 cycles after ack.
//   - The bus must ack before the master's first SCK edge of the next byte, or that byte carries
//     stale data.
//   - A late read is not an error.
//  Overrun: an rx byte in WR_BUS or RD_BUS sets o_err. The byte is dropped and the state is
//   unchanged.
//  csn high mid-frame: go to IDLE from any state, with one exception. If req=1, finish the
//   handshake (wait for ack, discard the result) first, then go to IDLE. No further bus access is
//   started.
//  Simultaneous rx_valid and ack in the same cycle: the ack is processed first; the rx byte
//   counts as an overrun.
//  Reset mid-operation: req drops immediately; the bus must tolerate an abandoned request.
// CONFIGURATION
//  SPI_BRIDGE_TIMEOUT_EN defined:
//   - A counter runs while req=1 and no ack arrives.
//   - At TIMEOUT_CYCLES: drop req and set o_err.
//   - A write goes to WR_WAIT without incrementing addr.
//   - A read goes to RD_LOAD with tx_data=8'hFF.
//  Not defined: req is held indefinitely until ack; there is no counter logic.
// TESTING
//  1. Write burst: rx 8'h85,8'hA1,8'hB2 -> bus writes (addr 5,A1) then (addr 6,B2); o_err=0.
//  2. Read burst: rx 8'h10, ack rdata=8'h3C then 8'h4D -> reads at addr 16,17; o_tx_valid pulses
//     with 3C then 4D.
//  3. Wrap: write command to addr 7'h7F with 2 data bytes -> accesses at 7F then 00.
//  4. Overrun: hold ack low, send 2nd write data byte -> o_err=1, 2nd byte dropped; next csn fall
//     clears o_err.
//  5. csn high while req pending -> req held until ack, then IDLE; no new request.
//     Reset mid-frame -> all outputs 0.
//  6. (SPI_BRIDGE_TIMEOUT_EN) read with ack never asserted -> req drops after 64 cycles; o_err=1;
//     o_tx_data=8'hFF.

Source files
------------

// File: rtl/spi_reg_bridge.sv
// SPI byte stream to req/ack register bus bridge with address auto-increment.
// Optional bus ack timeout is compiled in with `define SPI_BRIDGE_TIMEOUT_EN.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no frame; waiting for csn falling edge
// CMD     | waiting for command byte {rw, addr}
// WR_WAIT | waiting for next write data byte
// WR_BUS  | write request on the bus, waiting for ack
// RD_BUS  | read request on the bus (prefetch), waiting for ack
// RD_LOAD | hand captured read byte to the MISO loader
// RD_WAIT | waiting for the master to clock out the loaded byte
// DRAIN   | csn went high with a request pending; finish it, then IDLE
module spi_reg_bridge #(
    parameter int ADDR_W         = 7,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_spi_csn,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    output logic              o_tx_valid,
    output logic [7:0]        o_tx_data,
    output logic              o_bus_req,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [7:0]        o_bus_wdata,
    input  logic              i_bus_ack,
    input  logic [7:0]        i_bus_rdata,
    output logic              o_err
);

    typedef enum logic [2:0] {
        IDLE, CMD, WR_WAIT, WR_BUS, RD_BUS, RD_LOAD, RD_WAIT, DRAIN
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    if (ADDR_W < 1 || ADDR_W > 7 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("spi_reg_bridge: ADDR_W must be 1..7 and TIMEOUT_CYCLES >= 1");
    end

    state_t            state_q, state_d;
    logic              csn_q;
    logic              csn_fall;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              err_q, err_d;
    logic              req;
    logic              ack;
    logic              tmo;

    assign req      = state_q inside {WR_BUS, RD_BUS, DRAIN};
    assign ack      = req & i_bus_ack;
    assign csn_fall = csn_q & ~i_spi_csn;

`ifdef SPI_BRIDGE_TIMEOUT_EN
    localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]  TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q;

    // Down-counter reloads whenever no request is outstanding.
    always_ff @(posedge i_clk) begin
        if (!i_rstn || !req || i_bus_ack) begin
            tmo_cnt_q <= TMO_LOAD;
        end else if (tmo_cnt_q != '0) begin
            tmo_cnt_q <= tmo_cnt_q - TMO_W'(1);
        end
    end

    assign tmo = req & ~i_bus_ack & (tmo_cnt_q == '0);
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q    <= IDLE;
            csn_q      <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= 8'h00;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            csn_q      <= i_spi_csn;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        err_d      = err_q;

        if (csn_fall) begin
            err_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (csn_fall) state_d = CMD;
            end
            CMD: begin
                if (i_rx_valid) begin
                    we_d    = i_rx_data[7];
                    addr_d  = i_rx_data[ADDR_W-1:0];
                    state_d = i_rx_data[7] ? WR_WAIT : RD_BUS;
                end
            end
            WR_WAIT: begin
                if (i_rx_valid) begin
                    wdata_d = i_rx_data;
                    state_d = WR_BUS;
                end
            end
            WR_BUS: begin
                // An rx byte here is an overrun even if the ack lands in the same cycle.
                if (i_rx_valid) err_d = 1'b1;
                if (ack) begin
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = WR_WAIT;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = WR_WAIT;
                end
            end
            RD_BUS: begin
                if (i_rx_valid) err_d = 1'b1;
                if (ack) begin
                    tx_data_d = i_bus_rdata;
                    state_d   = RD_LOAD;
                end else if (tmo) begin
                    err_d     = 1'b1;
                    tx_data_d = 8'hFF;
                    state_d   = RD_LOAD;
                end
            end
            RD_LOAD: begin
                tx_valid_d = 1'b1;
                addr_d     = addr_q + ADDR_ONE;
                state_d    = RD_WAIT;
            end
            RD_WAIT: begin
                if (i_rx_valid) state_d = RD_BUS;
            end
            DRAIN: begin
                if (tmo) err_d = 1'b1;
                if (ack || tmo) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Frame end: an outstanding request is completed before returning to IDLE.
        if (i_spi_csn && state_q != IDLE) begin
            state_d    = (req && !ack && !tmo) ? DRAIN : IDLE;
            tx_valid_d = 1'b0;
        end
    end

    assign o_tx_valid  = tx_valid_q;
    assign o_tx_data   = tx_data_q;
    assign o_bus_req   = req;
    assign o_bus_we    = we_q;
    assign o_bus_addr  = addr_q;
    assign o_bus_wdata = wdata_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: table-driven frames with a bus/tx scoreboard,
// plus hand-written overrun, csn-abort, reset and (SPI_BRIDGE_TIMEOUT_EN) timeout sequences.
`timescale 1ns/1ps
module tb_spi_reg_bridge;
    localparam int ADDR_W = 7;
    localparam int GAP    = 10;

    logic              clk       = 1'b0;
    logic              rstn      = 1'b0;
    logic              spi_csn   = 1'b1;
    logic              rx_valid  = 1'b0;
    logic [7:0]        rx_data   = 8'h00;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [7:0]        bus_wdata;
    logic              bus_ack   = 1'b0;
    logic [7:0]        bus_rdata = 8'h00;
    logic              err;

    spi_reg_bridge #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(64)) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_spi_csn   (spi_csn),
        .i_rx_valid  (rx_valid),
        .i_rx_data   (rx_data),
        .o_tx_valid  (tx_valid),
        .o_tx_data   (tx_data),
        .o_bus_req   (bus_req),
        .o_bus_we    (bus_we),
        .o_bus_addr  (bus_addr),
        .o_bus_wdata (bus_wdata),
        .i_bus_ack   (bus_ack),
        .i_bus_rdata (bus_rdata),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        wdata;
    } bus_exp_t;

    typedef struct {
        logic [7:0]      cmd;
        int              n;
        logic [2:0][7:0] d;
        int              dly;
    } frame_t;

    bus_exp_t   exp_bus_q[$];
    logic [7:0] exp_tx_q[$];
    logic [7:0] rd_q[$];

    int n_checks    = 0;
    int n_fail      = 0;
    int cyc         = 0;
    int last_rd_ack = 0;
    int ack_delay   = 0;
    bit hold_ack    = 1'b0;
    bit lat_chk     = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus slave model: acks after ack_delay cycles and checks each access against the scoreboard.
    initial begin : responder
        int       wait_cnt;
        bus_exp_t e;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            bus_ack = 1'b0;
            if (!bus_req || !rstn) begin
                wait_cnt = 0;
            end else if (!hold_ack) begin
                if (wait_cnt < ack_delay) begin
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    bus_ack  = 1'b1;
                    check("bus_access_expected", exp_bus_q.size() > 0, 1);
                    if (exp_bus_q.size() > 0) begin
                        e = exp_bus_q.pop_front();
                        check("bus_we", bus_we, e.we);
                        check("bus_addr", bus_addr, e.addr);
                        if (e.we) begin
                            check("bus_wdata", bus_wdata, e.wdata);
                        end else begin
                            bus_rdata   = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hEE;
                            last_rd_ack = cyc;
                        end
                    end
                end
            end
        end
    end

    initial begin : tx_mon
        forever begin
            @(negedge clk);
            if (tx_valid) begin
                check("tx_expected", exp_tx_q.size() > 0, 1);
                if (exp_tx_q.size() > 0) check("tx_data", tx_data, exp_tx_q.pop_front());
                if (lat_chk) check("tx_latency", cyc - last_rd_ack, 2);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic frame_start();
        @(negedge clk);
        spi_csn = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic frame_end();
        @(negedge clk);
        spi_csn = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_bus_q.size() + exp_tx_q.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_bus_q.size() + exp_tx_q.size(), 0);
        exp_bus_q.delete();
        exp_tx_q.delete();
        rd_q.delete();
    endtask

    function automatic frame_t mk(input logic [7:0] cmd, input int n, input logic [7:0] d0,
                                  input logic [7:0] d1, input logic [7:0] d2, input int dly);
        frame_t f;
        f.cmd  = cmd;
        f.n    = n;
        f.d[0] = d0;
        f.d[1] = d1;
        f.d[2] = d2;
        f.dly  = dly;
        return f;
    endfunction

    task automatic run_frame(input frame_t f);
        logic [ADDR_W-1:0] a;
        bus_exp_t          e;
        ack_delay = f.dly;
        a = f.cmd[ADDR_W-1:0];
        for (int i = 0; i < f.n; i++) begin
            e.we    = f.cmd[7];
            e.addr  = a;
            e.wdata = f.d[i];
            exp_bus_q.push_back(e);
            if (!f.cmd[7]) begin
                rd_q.push_back(f.d[i]);
                exp_tx_q.push_back(f.d[i]);
            end
            a = a + ADDR_W'(1);
        end
        frame_start();
        send_byte(f.cmd);
        if (f.cmd[7]) begin
            for (int i = 0; i < f.n; i++) send_byte(f.d[i]);
        end else begin
            for (int i = 1; i < f.n; i++) send_byte(8'h00);
        end
        wait_drain("frame_drain");
        frame_end();
        check("frame_err", err, 0);
        check("frame_req_idle", bus_req, 0);
    endtask

    initial begin : main
        frame_t   frames[6];
        bus_exp_t e;
        int       n;

        frames[0] = mk(8'h85, 2, 8'hA1, 8'hB2, 8'h00, 0);  // write burst 05,06
        frames[1] = mk(8'h10, 2, 8'h3C, 8'h4D, 8'h00, 1);  // read burst 10,11
        frames[2] = mk(8'hFF, 2, 8'h11, 8'h22, 8'h00, 2);  // write wrap 7F,00
        frames[3] = mk(8'h7F, 2, 8'h5A, 8'hA5, 8'h00, 3);  // read wrap 7F,00
        frames[4] = mk(8'h80, 3, 8'h01, 8'h02, 8'h03, 1);
        frames[5] = mk(8'h2A, 3, 8'hC3, 8'h00, 8'hFF, 0);

        repeat (3) @(negedge clk);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_req", bus_req, 0);
        check("rst_we", bus_we, 0);
        check("rst_addr", bus_addr, 0);
        check("rst_wdata", bus_wdata, 0);
        check("rst_err", err, 0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 6; i++) run_frame(frames[i]);

        // Overrun: second data byte while the write is still pending.
        ack_delay = 0;
        hold_ack  = 1'b1;
        e.we = 1'b1; e.addr = 7'h20; e.wdata = 8'h55;
        exp_bus_q.push_back(e);
        frame_start();
        send_byte(8'hA0);
        send_byte(8'h55);
        send_byte(8'h66);
        check("ovr_err_set", err, 1);
        check("ovr_req_held", bus_req, 1);
        check("ovr_wdata_kept", bus_wdata, 8'h55);
        hold_ack = 1'b0;
        wait_drain("ovr_drain");
        frame_end();
        check("ovr_err_sticky", err, 1);
        frame_start();
        check("ovr_err_cleared", err, 0);
        frame_end();

        // csn high while a request is pending.
        hold_ack = 1'b1;
        e.we = 1'b1; e.addr = 7'h30; e.wdata = 8'h77;
        exp_bus_q.push_back(e);
        frame_start();
        send_byte(8'hB0);
        send_byte(8'h77);
        @(negedge clk);
        spi_csn = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_req_held", bus_req, 1);
        check("abort_addr_stable", bus_addr, 7'h30);
        hold_ack = 1'b0;
        wait_drain("abort_drain");
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus_req) n++;
        end
        check("abort_no_new_req", n, 0);

        // Reset in the middle of a pending write with err set.
        hold_ack = 1'b1;
        frame_start();
        send_byte(8'h90);
        send_byte(8'h5A);
        send_byte(8'h00);
        check("pre_rst_req", bus_req, 1);
        check("pre_rst_err", err, 1);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_tx_data", tx_data, 0);
        check("mid_rst_req", bus_req, 0);
        check("mid_rst_we", bus_we, 0);
        check("mid_rst_addr", bus_addr, 0);
        check("mid_rst_wdata", bus_wdata, 0);
        check("mid_rst_err", err, 0);
        rstn     = 1'b1;
        spi_csn  = 1'b1;
        hold_ack = 1'b0;
        repeat (3) @(negedge clk);

`ifdef SPI_BRIDGE_TIMEOUT_EN
        // Read that is never acked: request abandoned after 64 cycles, 8'hFF returned.
        hold_ack = 1'b1;
        lat_chk  = 1'b0;
        exp_tx_q.push_back(8'hFF);
        frame_start();
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h05;
        @(negedge clk);
        rx_valid = 1'b0;
        n = 0;
        while (bus_req && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("tmo_req_cycles", n, 64);
        check("tmo_err", err, 1);
        wait_drain("tmo_drain");
        frame_end();
        hold_ack = 1'b0;
        lat_chk  = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
